// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Post-EX destination tracking with youngest-first operand forwarding,
//            latency-aware issue stall and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int NUM_RP = 2,
    parameter int CNT_W  = 16,
    localparam int LAT_W = $clog2(STAGES),
    localparam int SEL_W = $clog2(STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic                       iss_we,
    input  logic [REG_AW-1:0]          iss_rd,
    input  logic [LAT_W-1:0]           iss_lat,
    input  logic                       flush,
    input  logic [NUM_RP-1:0]          rp_en,
    input  logic [NUM_RP*REG_AW-1:0]   rp_idx,
    input  logic [NUM_RP*XLEN-1:0]     rp_regdata,
    input  logic [STAGES*XLEN-1:0]     slot_data,
    output logic [NUM_RP*XLEN-1:0]     rp_data,
    output logic [NUM_RP*SEL_W-1:0]    rp_sel,
    output logic                       stall,
    output logic [STAGES-1:0]          slot_occ,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam logic [LAT_W-1:0] C_MAX_REM = LAT_W'(STAGES - 1);

    logic [STAGES-1:0]  r_slotV;
    logic [STAGES-1:0]  r_slotWe;
    logic [REG_AW-1:0]  r_slotRd  [STAGES];
    logic [LAT_W-1:0]   r_slotRem [STAGES];
    logic [CNT_W-1:0]   r_stallCnt;

    logic               w_stall;
    logic               w_transfer;
    logic [LAT_W-1:0]   w_issRem;
    logic [NUM_RP-1:0]  w_hit;
    logic [LAT_W-1:0]   w_hitIdx [NUM_RP];

    assign w_transfer = iss_valid & ~w_stall;
    assign w_issRem   = (iss_lat > C_MAX_REM) ? C_MAX_REM : iss_lat;
    assign iss_ready  = ~w_stall;
    assign stall      = w_stall;
    assign slot_occ   = r_slotV & r_slotWe;
    assign stall_cnt  = r_stallCnt;

    // Scan oldest to youngest so the youngest match overwrites; a pending
    // youngest match must block rather than forward an older value.
    always_comb begin
        w_stall = 1'b0;
        rp_data = rp_regdata;
        rp_sel  = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            w_hit[p]    = 1'b0;
            w_hitIdx[p] = '0;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (rp_en[p] && (rp_idx[p*REG_AW +: REG_AW] != '0) &&
                    r_slotV[k] && r_slotWe[k] &&
                    (r_slotRd[k] == rp_idx[p*REG_AW +: REG_AW])) begin
                    w_hit[p]    = 1'b1;
                    w_hitIdx[p] = LAT_W'(k);
                end
            end
            if (w_hit[p]) begin
                if (r_slotRem[w_hitIdx[p]] == '0) begin
                    rp_data[p*XLEN +: XLEN]  = slot_data[w_hitIdx[p]*XLEN +: XLEN];
                    rp_sel[p*SEL_W +: SEL_W] = SEL_W'(w_hitIdx[p]) + SEL_W'(1);
                end else begin
                    w_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slotV    <= '0;
            r_slotWe   <= '0;
            r_stallCnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_slotRd[k]  <= '0;
                r_slotRem[k] <= '0;
            end
        end else begin
            // Slots advance unconditionally; a stall only bubbles slot0.
            for (int k = 1; k < STAGES; k++) begin
                r_slotV[k]   <= r_slotV[k-1] & ~flush;
                r_slotWe[k]  <= r_slotWe[k-1];
                r_slotRd[k]  <= r_slotRd[k-1];
                r_slotRem[k] <= (r_slotRem[k-1] == '0) ? '0 : r_slotRem[k-1] - 1'b1;
            end
            r_slotV[0]   <= w_transfer & ~flush;
            r_slotWe[0]  <= iss_we;
            r_slotRd[0]  <= iss_rd;
            r_slotRem[0] <= w_issRem;

            if (cnt_clr) begin
                r_stallCnt <= '0;
            end else if (w_stall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// Testbench for fwd_scoreboard: directed vector table, constrained-random run
// against an age-based reference model, counter saturation and async reset.
module tb_fwd_scoreboard;

    localparam int XLEN = 32, REG_AW = 5, STAGES = 3, NUM_RP = 2, CNT_W = 16, SAT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid, iss_we, flush, cnt_clr;
    logic [4:0]  iss_rd;
    logic [1:0]  iss_lat;
    logic [1:0]  rp_en;
    logic [9:0]  rp_idx;
    logic [63:0] rp_regdata;
    logic [95:0] slot_data;

    logic        iss_ready, stall, satReady, satStall;
    logic [63:0] rp_data, satData;
    logic [3:0]  rp_sel, satSel;
    logic [2:0]  slot_occ, satOcc;
    logic [15:0] stall_cnt;
    logic [3:0]  satCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .STAGES(STAGES), .NUM_RP(NUM_RP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_we(iss_we),
        .iss_rd(iss_rd), .iss_lat(iss_lat), .flush(flush), .rp_en(rp_en), .rp_idx(rp_idx),
        .rp_regdata(rp_regdata), .slot_data(slot_data), .rp_data(rp_data), .rp_sel(rp_sel),
        .stall(stall), .slot_occ(slot_occ), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt));

    fwd_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .STAGES(STAGES), .NUM_RP(NUM_RP), .CNT_W(SAT_W)) dutSat (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(satReady), .iss_we(iss_we),
        .iss_rd(iss_rd), .iss_lat(iss_lat), .flush(flush), .rp_en(rp_en), .rp_idx(rp_idx),
        .rp_regdata(rp_regdata), .slot_data(slot_data), .rp_data(satData), .rp_sel(satSel),
        .stall(satStall), .slot_occ(satOcc), .cnt_clr(cnt_clr), .stall_cnt(satCnt));

    // Reference model: in-flight instructions by age since entering slot0.
    typedef struct {
        int         age;
        logic [4:0] rd;
        logic       we;
        int         lat;
    } ent_t;

    ent_t        q[$];
    int          tot = 0;
    logic        mStall;
    logic [1:0]  mSel [2];
    logic [31:0] mData [2];

    function automatic int satVal(int t, int w);
        int mx = (1 << w) - 1;
        return (t > mx) ? mx : t;
    endfunction

    function automatic void modelEval();
        mStall = 1'b0;
        for (int p = 0; p < 2; p++) begin
            logic [4:0] idx = rp_idx[p*5 +: 5];
            mSel[p]  = 2'd0;
            mData[p] = rp_regdata[p*32 +: 32];
            if (rp_en[p] && idx != 5'd0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].we && q[i].rd == idx) begin
                        int eff = (q[i].lat > STAGES - 1) ? STAGES - 1 : q[i].lat;
                        if (q[i].age >= eff) begin
                            mSel[p]  = 2'(q[i].age + 1);
                            mData[p] = slot_data[q[i].age*32 +: 32];
                        end else begin
                            mStall = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic logic [2:0] modelOcc();
        logic [2:0] o = 3'b000;
        foreach (q[i]) if (q[i].we) o[q[i].age] = 1'b1;
        return o;
    endfunction

    function automatic void modelEdge();
        ent_t nq[$];
        logic xfer = iss_valid && !mStall;
        foreach (q[i]) begin
            ent_t e = q[i];
            e.age = e.age + 1;
            if (e.age < STAGES) nq.push_back(e);
        end
        q = nq;
        if (flush) q.delete();
        if (xfer && !flush) q.push_front('{0, iss_rd, iss_we, int'(iss_lat)});
        if (cnt_clr) tot = 0;
        else if (mStall) tot++;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        chk("stall", 64'(stall), 64'(mStall));
        chk("iss_ready", 64'(iss_ready), 64'(!mStall));
        for (int p = 0; p < 2; p++) begin
            chk("rp_sel", 64'(rp_sel[p*2 +: 2]), 64'(mSel[p]));
            chk("rp_data", 64'(rp_data[p*32 +: 32]), 64'(mData[p]));
        end
        chk("slot_occ", 64'(slot_occ), 64'(modelOcc()));
        chk("stall_cnt", 64'(stall_cnt), 64'(satVal(tot, CNT_W)));
        chk("sat_cnt", 64'(satCnt), 64'(satVal(tot, SAT_W)));
    endtask

    task automatic halfA();
        @(negedge clk);
        modelEval();
    endtask

    task automatic halfB();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic cycle(input bit doChk);
        halfA();
        if (doChk) checkAll();
        halfB();
    endtask

    task automatic drive(input int iv, input int we, input int rd, input int lat,
                         input int fl, input int en, input int i0, input int i1);
        iss_valid = 1'(iv);
        iss_we    = 1'(we);
        iss_rd    = 5'(rd);
        iss_lat   = 2'(lat);
        flush     = 1'(fl);
        rp_en     = 2'(en);
        rp_idx    = {5'(i1), 5'(i0)};
    endtask

    typedef struct {
        int iv, we, rd, lat, fl, en, i0, i1;
        int eStall, eSel0, eSel1, eOcc, eCnt;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] expData(int p, int sel);
        logic [95:0] sd = slot_data;
        logic [63:0] rd = rp_regdata;
        if (sel == 0) return rd[p*32 +: 32];
        return sd[(sel-1)*32 +: 32];
    endfunction

    initial begin
        //          iv we rd lat fl en i0 i1  stall sel0 sel1 occ  cnt
        tbl[0]  = '{0, 0, 0, 0,  0, 3, 5, 3,  0,    0,   0,   0,   0};
        tbl[1]  = '{1, 1, 3, 0,  0, 3, 5, 3,  0,    0,   0,   0,   0};
        tbl[2]  = '{1, 1, 3, 0,  0, 3, 3, 5,  0,    1,   0,   1,   0};
        tbl[3]  = '{0, 0, 0, 0,  0, 3, 3, 5,  0,    1,   0,   3,   0};
        tbl[4]  = '{0, 0, 0, 0,  0, 3, 3, 5,  0,    2,   0,   6,   0};
        tbl[5]  = '{0, 0, 0, 0,  0, 3, 3, 5,  0,    3,   0,   4,   0};
        tbl[6]  = '{1, 1, 7, 1,  0, 3, 3, 5,  0,    0,   0,   0,   0};
        tbl[7]  = '{1, 1, 8, 0,  0, 3, 7, 5,  1,    0,   0,   1,   0};
        tbl[8]  = '{1, 1, 8, 0,  0, 3, 7, 5,  0,    2,   0,   2,   1};
        tbl[9]  = '{0, 0, 0, 0,  0, 3, 7, 8,  0,    3,   1,   5,   1};
        tbl[10] = '{1, 1, 0, 2,  0, 3, 0, 0,  0,    0,   0,   2,   1};
        tbl[11] = '{0, 0, 0, 0,  0, 3, 0, 8,  0,    0,   3,   5,   1};
        tbl[12] = '{1, 1, 9, 2,  0, 0, 9, 9,  0,    0,   0,   2,   1};
        tbl[13] = '{1, 1, 9, 2,  1, 0, 9, 9,  0,    0,   0,   5,   1};
        tbl[14] = '{0, 0, 0, 0,  0, 3, 9, 9,  0,    0,   0,   0,   1};
        tbl[15] = '{0, 0, 0, 0,  0, 3, 9, 9,  0,    0,   0,   0,   1};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cnt_clr    = 1'b0;
        slot_data  = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        rp_regdata = {32'h2222_2222, 32'h1111_1111};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table
        foreach (tbl[r]) begin
            drive(tbl[r].iv, tbl[r].we, tbl[r].rd, tbl[r].lat, tbl[r].fl, tbl[r].en, tbl[r].i0, tbl[r].i1);
            halfA();
            chk($sformatf("tbl%0d.stall", r), 64'(stall), 64'(tbl[r].eStall));
            chk($sformatf("tbl%0d.ready", r), 64'(iss_ready), 64'(!tbl[r].eStall));
            chk($sformatf("tbl%0d.sel0", r), 64'(rp_sel[1:0]), 64'(tbl[r].eSel0));
            chk($sformatf("tbl%0d.sel1", r), 64'(rp_sel[3:2]), 64'(tbl[r].eSel1));
            chk($sformatf("tbl%0d.data0", r), 64'(rp_data[31:0]), 64'(expData(0, tbl[r].eSel0)));
            chk($sformatf("tbl%0d.data1", r), 64'(rp_data[63:32]), 64'(expData(1, tbl[r].eSel1)));
            chk($sformatf("tbl%0d.occ", r), 64'(slot_occ), 64'(tbl[r].eOcc));
            chk($sformatf("tbl%0d.cnt", r), 64'(stall_cnt), 64'(tbl[r].eCnt));
            halfB();
        end

        // Constrained random against the model
        for (int n = 0; n < 600; n++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            cnt_clr    = ($urandom_range(0, 31) == 0);
            slot_data  = {$urandom, $urandom, $urandom};
            rp_regdata = {$urandom, $urandom};
            cycle(1'b1);
        end
        cnt_clr = 1'b0;

        // Repeated lat=2 producer/consumer pairs saturate the narrow counter
        for (int n = 0; n < 12; n++) begin
            drive(1, 1, 7, 2, 0, 1, 7, 0);
            cycle(1'b1);
            drive(0, 0, 0, 0, 0, 1, 7, 0);
            cycle(1'b1);
            cycle(1'b1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        halfA();
        checkAll();
        chk("sat_hold", 64'(satCnt), 64'(4'hF));
        halfB();
        cnt_clr = 1'b1;
        cycle(1'b1);
        cnt_clr = 1'b0;
        halfA();
        checkAll();
        chk("cnt_clr16", 64'(stall_cnt), 64'(0));
        chk("cnt_clr4", 64'(satCnt), 64'(0));
        halfB();

        // Async reset while a consumer is stalled
        drive(1, 1, 7, 2, 0, 0, 0, 0);
        cycle(1'b1);
        drive(0, 0, 0, 0, 0, 1, 7, 0);
        cycle(1'b1);
        #2;
        chk("pre_rst_stall", 64'(stall), 64'(1));
        chk("pre_rst_cnt", 64'(stall_cnt), 64'(1));
        rst_n = 1'b0;
        #1;
        q.delete();
        tot = 0;
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_ready", 64'(iss_ready), 64'(1));
        chk("rst_sel", 64'(rp_sel), 64'(0));
        chk("rst_data", rp_data, rp_regdata);
        chk("rst_occ", 64'(slot_occ), 64'(0));
        chk("rst_cnt", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1);
        cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
